// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, reset/halt addresses and word width.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] MIPS_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [INSTR_W-1:0] MIPS_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN,
    DELAY,
    HALTED
  } fetch_state_t;

  // Instruction addresses are word-aligned; the low two bits carry no meaning.
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_pc_reg.sv
// Program counter register: synchronous reset to the boot vector, loads only when enabled.
module mips_pc_reg
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VECTOR = MIPS_RESET_VECTOR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] pc_d_i,
  output logic [INSTR_W-1:0] pc_q_o
);

  logic [INSTR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else if (load_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_q_o = pc_q;

endmodule

// File: rtl/mips_cpu_fetch.sv
// Instruction-fetch stage: owns the PC, implements the branch delay slot and halt detection.
//   state  | meaning
//   RUN    | sequential fetch; a redirect here schedules its target after the delay slot
//   DELAY  | delay-slot instruction on the bus; next advance jumps to target_q
//   HALTED | jumped to HALT_ADDR; frozen until reset
module mips_cpu_fetch
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VECTOR = MIPS_RESET_VECTOR,
  parameter logic [INSTR_W-1:0] HALT_ADDR    = MIPS_HALT_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_target,
  output logic [INSTR_W-1:0] instr_address,
  input  logic [INSTR_W-1:0] instr_readdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] pc_out,
  output logic [INSTR_W-1:0] pc_plus8,
  output logic               instr_valid,
  output logic               active
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] target_q, target_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic               pc_load;
  logic               advance;

  mips_pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .load_i (pc_load),
    .pc_d_i (pc_d),
    .pc_q_o (pc_q)
  );

  assign advance = clk_enable & ~stall & (state_q != HALTED);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pc_d     = pc_q + 32'd4;
    pc_load  = 1'b0;
    if (advance) begin
      unique case (state_q)
        RUN: begin
          pc_load = 1'b1;
          if (redirect_valid) begin
            target_d = word_align(redirect_target);
            state_d  = DELAY;
          end
        end
        DELAY: begin
          // A redirect seen here would be a branch in a delay slot; it is ignored.
          pc_load = 1'b1;
          if (target_q == HALT_ADDR) begin
            pc_d    = HALT_ADDR;
            state_d = HALTED;
          end else begin
            pc_d    = target_q;
            state_d = RUN;
          end
        end
        default: begin
          pc_load = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign instr_address = pc_q;
  assign pc_out        = pc_q;
  assign pc_plus8      = pc_q + 32'd8;
  assign instr_out     = instr_readdata;
  assign active        = (state_q != HALTED);
  assign instr_valid   = active;

endmodule
